// File: rtl/uart_ctrl_mon_pkg.sv
// Shared types and helpers for the UART controller FIFO occupancy monitor.
// Histogram support is compiled in with UART_CTRL_FIFO_MON_HIST_EN.
package uart_ctrl_mon_pkg;

    typedef enum logic [0:0] {
        THR_LOW  = 1'b0,
        THR_HIGH = 1'b1
    } thr_state_e;

    localparam int HIST_BINS  = 4;
    localparam int HIST_CNT_W = 16;

    // bin0: empty, bin1: below half, bin2: half up to not full, bin3: full
    function automatic logic [1:0] hist_bin(input int unsigned occ, input int unsigned depth);
        if (occ == 0)
            return 2'd0;
        else if (occ >= depth)
            return 2'd3;
        else if (occ < depth / 2)
            return 2'd1;
        else
            return 2'd2;
    endfunction

endpackage

// File: rtl/uart_ctrl_fifo_mon_chan.sv
// One monitored FIFO channel: occupancy, flags, high-water mark, threshold FSM and,
// with UART_CTRL_FIFO_MON_HIST_EN defined, an occupancy histogram.
module uart_ctrl_fifo_mon_chan
    import uart_ctrl_mon_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int HI_THR = 12,
    parameter  int LO_THR = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] occ_o,
    output logic [CNT_W-1:0] hwm_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_o,
    output logic             udf_o,
    output logic             thr_hi_evt_o,
`ifdef UART_CTRL_FIFO_MON_HIST_EN
    output logic [HIST_BINS*HIST_CNT_W-1:0] hist_o,
`endif
    output logic             thr_lo_evt_o
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] HI_C    = CNT_W'(HI_THR);
    localparam logic [CNT_W-1:0] LO_C    = CNT_W'(LO_THR);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [CNT_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] hwm_q, hwm_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             hi_evt_q, hi_evt_d;
    logic             lo_evt_q, lo_evt_d;
    thr_state_e       state_q, state_d;
    logic             ovf_set, udf_set;

    always_comb begin
        occ_d   = occ_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        unique case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == DEPTH_C) ovf_set = 1'b1;
                else                  occ_d   = occ_q + ONE_C;
            end
            2'b01: begin
                if (occ_q == '0) udf_set = 1'b1;
                else             occ_d   = occ_q - ONE_C;
            end
            // On an empty FIFO the pop is rejected but the push still lands;
            // when full, the pop frees the slot the push then takes.
            2'b11: begin
                if (occ_q == '0) begin
                    occ_d   = ONE_C;
                    udf_set = 1'b1;
                end
            end
            default: ;
        endcase

        if (clear_i)
            hwm_d = occ_d;
        else if (occ_d > hwm_q)
            hwm_d = occ_d;
        else
            hwm_d = hwm_q;

        ovf_d   = ovf_set | (ovf_q & ~clear_i);
        udf_d   = udf_set | (udf_q & ~clear_i);
        full_d  = (occ_d == DEPTH_C);
        empty_d = (occ_d == '0);

        state_d  = state_q;
        hi_evt_d = 1'b0;
        lo_evt_d = 1'b0;
        if (state_q == THR_LOW) begin
            if (occ_d >= HI_C) begin
                state_d  = THR_HIGH;
                hi_evt_d = 1'b1;
            end
        end else begin
            if (occ_d <= LO_C) begin
                state_d  = THR_LOW;
                lo_evt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occ_q    <= '0;
            hwm_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            hi_evt_q <= 1'b0;
            lo_evt_q <= 1'b0;
            state_q  <= THR_LOW;
        end else begin
            occ_q    <= occ_d;
            hwm_q    <= hwm_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            hi_evt_q <= hi_evt_d;
            lo_evt_q <= lo_evt_d;
            state_q  <= state_d;
        end
    end

    assign occ_o        = occ_q;
    assign hwm_o        = hwm_q;
    assign full_o       = full_q;
    assign empty_o      = empty_q;
    assign ovf_o        = ovf_q;
    assign udf_o        = udf_q;
    assign thr_hi_evt_o = hi_evt_q;
    assign thr_lo_evt_o = lo_evt_q;

`ifdef UART_CTRL_FIFO_MON_HIST_EN
    // Bins sample the registered occupancy, i.e. what software currently sees.
    logic [HIST_CNT_W-1:0] hist_q [HIST_BINS];
    logic [HIST_CNT_W-1:0] hist_d [HIST_BINS];
    logic [1:0]            bin_sel;

    always_comb begin
        bin_sel = hist_bin(32'(occ_q), DEPTH);
        for (int b = 0; b < HIST_BINS; b++) hist_d[b] = hist_q[b];
        if (clear_i) begin
            for (int b = 0; b < HIST_BINS; b++) hist_d[b] = '0;
        end else if (hist_q[bin_sel] != '1) begin
            hist_d[bin_sel] = hist_q[bin_sel] + HIST_CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < HIST_BINS; b++) hist_q[b] <= '0;
        end else begin
            for (int b = 0; b < HIST_BINS; b++) hist_q[b] <= hist_d[b];
        end
    end

    for (genvar b = 0; b < HIST_BINS; b++) begin : g_hist_pack
        assign hist_o[b*HIST_CNT_W +: HIST_CNT_W] = hist_q[b];
    end
`endif

endmodule

// File: rtl/uart_ctrl_fifo_monitor.sv
// Multi-channel UART FIFO occupancy monitor (ch0 = TX, ch1 = RX by default).
// Define UART_CTRL_FIFO_MON_HIST_EN to add the per-channel histogram output hist_o.
module uart_ctrl_fifo_monitor
    import uart_ctrl_mon_pkg::*;
#(
    parameter  int NUM_CH = 2,
    parameter  int DEPTH  = 16,
    parameter  int HI_THR = 12,
    parameter  int LO_THR = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       push_i,
    input  logic [NUM_CH-1:0]       pop_i,
    input  logic [NUM_CH-1:0]       clear_i,
    output logic [NUM_CH*CNT_W-1:0] occ_o,
    output logic [NUM_CH*CNT_W-1:0] hwm_o,
    output logic [NUM_CH-1:0]       full_o,
    output logic [NUM_CH-1:0]       empty_o,
    output logic [NUM_CH-1:0]       ovf_o,
    output logic [NUM_CH-1:0]       udf_o,
    output logic [NUM_CH-1:0]       thr_hi_evt_o,
`ifdef UART_CTRL_FIFO_MON_HIST_EN
    output logic [NUM_CH*HIST_BINS*HIST_CNT_W-1:0] hist_o,
`endif
    output logic [NUM_CH-1:0]       thr_lo_evt_o
);

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("uart_ctrl_fifo_monitor: NUM_CH must be 1..8");
    end
    if (LO_THR >= HI_THR) begin : g_bad_thr_order
        $error("uart_ctrl_fifo_monitor: LO_THR must be below HI_THR");
    end
    if (HI_THR > DEPTH) begin : g_bad_hi_thr
        $error("uart_ctrl_fifo_monitor: HI_THR must not exceed DEPTH");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("uart_ctrl_fifo_monitor: DEPTH must be at least 2");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        uart_ctrl_fifo_mon_chan #(
            .DEPTH  (DEPTH),
            .HI_THR (HI_THR),
            .LO_THR (LO_THR)
        ) u_chan (
            .clock        (clock),
            .reset_n      (reset_n),
            .push_i       (push_i[c]),
            .pop_i        (pop_i[c]),
            .clear_i      (clear_i[c]),
            .occ_o        (occ_o[c*CNT_W +: CNT_W]),
            .hwm_o        (hwm_o[c*CNT_W +: CNT_W]),
            .full_o       (full_o[c]),
            .empty_o      (empty_o[c]),
            .ovf_o        (ovf_o[c]),
            .udf_o        (udf_o[c]),
            .thr_hi_evt_o (thr_hi_evt_o[c]),
`ifdef UART_CTRL_FIFO_MON_HIST_EN
            .hist_o       (hist_o[c*HIST_BINS*HIST_CNT_W +: HIST_BINS*HIST_CNT_W]),
`endif
            .thr_lo_evt_o (thr_lo_evt_o[c])
        );
    end

endmodule

// File: tb/tb_uart_ctrl_fifo_monitor.sv
// Testbench for uart_ctrl_fifo_monitor: directed scenarios plus random traffic
// checked against an accept/reject occupancy model.
module tb_uart_ctrl_fifo_monitor;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 16;
    localparam int HI_THR = 12;
    localparam int LO_THR = 4;
    localparam int CNT_W  = 5;

    logic                    clock = 1'b0;
    logic                    reset_n;
    logic [NUM_CH-1:0]       push_i, pop_i, clear_i;
    logic [NUM_CH*CNT_W-1:0] occ_o, hwm_o;
    logic [NUM_CH-1:0]       full_o, empty_o, ovf_o, udf_o, thr_hi_evt_o, thr_lo_evt_o;
`ifdef UART_CTRL_FIFO_MON_HIST_EN
    logic [NUM_CH*64-1:0]    hist_o;
`endif

    always #5 clock = ~clock;

    uart_ctrl_fifo_monitor #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .HI_THR (HI_THR),
        .LO_THR (LO_THR)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .push_i       (push_i),
        .pop_i        (pop_i),
        .clear_i      (clear_i),
        .occ_o        (occ_o),
        .hwm_o        (hwm_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .ovf_o        (ovf_o),
        .udf_o        (udf_o),
        .thr_hi_evt_o (thr_hi_evt_o),
`ifdef UART_CTRL_FIFO_MON_HIST_EN
        .hist_o       (hist_o),
`endif
        .thr_lo_evt_o (thr_lo_evt_o)
    );

    int total = 0;
    int bad   = 0;

    // reference state per channel
    int m_occ  [NUM_CH];
    int m_hwm  [NUM_CH];
    bit m_ovf  [NUM_CH];
    bit m_udf  [NUM_CH];
    bit m_high [NUM_CH];
    bit m_hi   [NUM_CH];
    bit m_lo   [NUM_CH];

    int hi_cnt0, lo_cnt0, hi_at0, lo_at0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_occ[c] = 0; m_hwm[c] = 0; m_ovf[c] = 0; m_udf[c] = 0;
            m_high[c] = 0; m_hi[c] = 0; m_lo[c] = 0;
        end
    endtask

    task automatic model_step(input logic [NUM_CH-1:0] p, q, cl);
        for (int c = 0; c < NUM_CH; c++) begin
            bit acc_pop, acc_push;
            int n;
            acc_pop  = q[c] && (m_occ[c] > 0);
            acc_push = p[c] && ((m_occ[c] < DEPTH) || acc_pop);
            n = m_occ[c] + (acc_push ? 1 : 0) - (acc_pop ? 1 : 0);
            m_ovf[c] = (p[c] && !acc_push) || (m_ovf[c] && !cl[c]);
            m_udf[c] = (q[c] && !acc_pop)  || (m_udf[c] && !cl[c]);
            m_hwm[c] = cl[c] ? n : ((n > m_hwm[c]) ? n : m_hwm[c]);
            m_hi[c] = 0;
            m_lo[c] = 0;
            if (!m_high[c] && n >= HI_THR) begin
                m_high[c] = 1; m_hi[c] = 1;
            end else if (m_high[c] && n <= LO_THR) begin
                m_high[c] = 0; m_lo[c] = 1;
            end
            m_occ[c] = n;
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NUM_CH; c++) begin
            check_val($sformatf("occ%0d", c),   occ_o[c*CNT_W +: CNT_W], m_occ[c]);
            check_val($sformatf("hwm%0d", c),   hwm_o[c*CNT_W +: CNT_W], m_hwm[c]);
            check_val($sformatf("full%0d", c),  full_o[c],  m_occ[c] == DEPTH);
            check_val($sformatf("empty%0d", c), empty_o[c], m_occ[c] == 0);
            check_val($sformatf("ovf%0d", c),   ovf_o[c],   m_ovf[c]);
            check_val($sformatf("udf%0d", c),   udf_o[c],   m_udf[c]);
            check_val($sformatf("hievt%0d", c), thr_hi_evt_o[c], m_hi[c]);
            check_val($sformatf("loevt%0d", c), thr_lo_evt_o[c], m_lo[c]);
        end
    endtask

    task automatic step(input logic [NUM_CH-1:0] p, q, cl);
        push_i  = p;
        pop_i   = q;
        clear_i = cl;
        @(posedge clock);
        model_step(p, q, cl);
        #1;
        check_all();
        if (thr_hi_evt_o[0]) begin hi_cnt0++; hi_at0 = int'(occ_o[CNT_W-1:0]); end
        if (thr_lo_evt_o[0]) begin lo_cnt0++; lo_at0 = int'(occ_o[CNT_W-1:0]); end
    endtask

    task automatic push_n(input int ch, input int n);
        for (int i = 0; i < n; i++) step(NUM_CH'(1 << ch), '0, '0);
    endtask

    task automatic pop_n(input int ch, input int n);
        for (int i = 0; i < n; i++) step('0, NUM_CH'(1 << ch), '0);
    endtask

    initial begin
        reset_n = 1'b0;
        push_i  = '0;
        pop_i   = '0;
        clear_i = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        reset_n = 1'b1;

        // asynchronous reset in the middle of a cycle at occ=7
        push_n(0, 7);
        push_n(1, 3);
        check_val("pre_rst_occ0", occ_o[CNT_W-1:0], 7);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        step('0, '0, '0);

        // fill ch0, then one push too many
        hi_cnt0 = 0; hi_at0 = -1;
        push_n(0, 16);
        check_val("fill_occ0",   occ_o[CNT_W-1:0], 16);
        check_val("fill_full0",  full_o[0], 1);
        check_val("fill_hi_cnt", hi_cnt0, 1);
        check_val("fill_hi_at",  hi_at0, 12);
        step(2'b01, '0, '0);
        check_val("ovf0_set",    ovf_o[0], 1);
        check_val("ovf_occ0",    occ_o[CNT_W-1:0], 16);

        // underflow on empty ch1, then push+pop on empty ch1
        step('0, 2'b10, '0);
        check_val("udf1_set", udf_o[1], 1);
        step(2'b10, 2'b10, '0);
        check_val("pp_empty_occ1", occ_o[2*CNT_W-1:CNT_W], 1);
        check_val("ch0_untouched", occ_o[CNT_W-1:0], 16);

        // hysteresis
        pop_n(0, 16);
        hi_cnt0 = 0; lo_cnt0 = 0; lo_at0 = -1;
        push_n(0, 13);
        pop_n(0, 8);
        push_n(0, 6);
        pop_n(0, 7);
        check_val("hyst_hi_cnt", hi_cnt0, 1);
        check_val("hyst_lo_cnt", lo_cnt0, 1);
        check_val("hyst_lo_at",  lo_at0, 4);

        // full with simultaneous push+pop
        push_n(0, 12);
        step('0, '0, 2'b01);
        for (int i = 0; i < 10; i++) step(2'b01, 2'b01, '0);
        check_val("fullpp_occ0", occ_o[CNT_W-1:0], 16);
        check_val("fullpp_ovf0", ovf_o[0], 0);

        // clear at occ=9 with hwm=14
        pop_n(0, 16);
        step('0, '0, 2'b01);
        push_n(0, 14);
        pop_n(0, 5);
        check_val("pre_clr_hwm0", hwm_o[CNT_W-1:0], 14);
        step('0, '0, 2'b01);
        check_val("clr_hwm0", hwm_o[CNT_W-1:0], 9);
        check_val("clr_ovf0", ovf_o[0], 0);
        check_val("clr_udf0", udf_o[0], 0);

        // random traffic with phases biased toward filling or draining
        for (int ph = 0; ph < 16; ph++) begin
            int pp, qp;
            pp = $urandom_range(10, 90);
            qp = $urandom_range(10, 90);
            for (int i = 0; i < 150; i++) begin
                logic [NUM_CH-1:0] p, q, cl;
                for (int c = 0; c < NUM_CH; c++) begin
                    p[c]  = ($urandom_range(0, 99) < pp);
                    q[c]  = ($urandom_range(0, 99) < qp);
                    cl[c] = ($urandom_range(0, 39) == 0);
                end
                step(p, q, cl);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
